// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath selects, strobes and ALU operation combinationally.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL = OP_W'(7'b1101111);

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b011);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b101);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_FUNCT = 2'd2
    } alu_op_t;

    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_op;

    assign state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic; unused codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW)      state_d = S_MEMWRITE;
                else if (op == OP_LW) state_d = S_MEMREAD;
                else                  state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state selects and strobes; strobes forced low while reset is held
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = AOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = AOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = AOP_FUNCT;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = AOP_SUB;
                PCWrite = Zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU decode; funct3=000 subtracts only for R-type with funct7[5] set
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            AOP_SUB:   ALUControl = ALU_SUB;
            AOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:   ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: vector table over whole instructions
// plus hand sequences for latency and reset during a memory stall.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] ILL = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic        zero;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl}
    function automatic logic [19:0] ex(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic rw, input logic [2:0] alu);
        return {st, pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu};
    endfunction

    function automatic logic [19:0] outs();
        return {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegWrite, ALUControl};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic [19:0] e);
        vec_t v;
        v.rst_n = r; v.op = o; v.f3 = f3; v.f75 = f7; v.zero = z; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Cycles from FETCH back to FETCH with no memory wait
    task automatic latency(input logic [6:0] o, input int want, input string name);
        int n;
        n = 0;
        @(negedge clk);
        op = o; mem_ready = 1'b1; Zero = 1'b0; funct3 = 3'b000; funct7_5 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (state == 4'd0) break;
        end
        check(name, n, want);
    endtask

    initial begin
        rst_n = 1'b1; op = LW; funct3 = 3'b000; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        #1 rst_n = 1'b0;

        // reset holds FETCH with strobes low even though mem_ready=1
        add(0, LW, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(0, LW, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        // lw: 0,1,2,3,4
        add(1, LW, 0, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, LW, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        add(1, LW, 0, 0, 0, 1, ex(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        add(1, LW, 0, 0, 0, 1, ex(3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000));
        add(1, LW, 0, 0, 0, 1, ex(4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000));
        // R-type sub
        add(1, RT, 0, 1, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, RT, 0, 1, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        add(1, RT, 0, 1, 0, 1, ex(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001));
        add(1, RT, 0, 1, 0, 1, ex(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));
        // I-ALU same encoding -> add
        add(1, IA, 0, 1, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, IA, 0, 1, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        add(1, IA, 0, 1, 0, 1, ex(7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000));
        add(1, IA, 0, 1, 0, 1, ex(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));
        // R-type and (111), then I-ALU slt (010) and or (110)
        add(1, RT, 7, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, RT, 7, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        add(1, RT, 7, 0, 0, 1, ex(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b010));
        add(1, RT, 7, 0, 0, 1, ex(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));
        add(1, IA, 2, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, IA, 2, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        add(1, IA, 2, 0, 0, 1, ex(7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b101));
        add(1, IA, 6, 0, 0, 1, ex(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000));
        // beq taken, then not taken
        add(1, BQ, 0, 0, 1, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        add(1, BQ, 0, 0, 1, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 3'b000));
        add(1, BQ, 0, 0, 1, 1, ex(9, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001));
        add(1, BQ, 0, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 0, 3'b000));
        add(1, BQ, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 3'b000));
        add(1, BQ, 0, 0, 0, 1, ex(9, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001));
        // sw with 3 wait cycles in MEMWRITE
        add(1, SW, 0, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 0, 3'b000));
        add(1, SW, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 0, 3'b000));
        add(1, SW, 0, 0, 0, 1, ex(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000));
        add(1, SW, 0, 0, 0, 0, ex(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000));
        add(1, SW, 0, 0, 0, 0, ex(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000));
        add(1, SW, 0, 0, 0, 0, ex(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000));
        add(1, SW, 0, 0, 0, 1, ex(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000));
        // jal
        add(1, JL, 0, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b11, 0, 3'b000));
        add(1, JL, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 0, 3'b000));
        add(1, JL, 0, 0, 0, 1, ex(10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000));
        add(1, JL, 0, 0, 0, 1, ex(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 3'b000));
        // fetch stall of 2 cycles, then illegal opcode back to FETCH
        add(1, ILL, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, ILL, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, ILL, 0, 0, 0, 1, ex(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));
        add(1, ILL, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 3'b000));
        add(1, ILL, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; op = vecs[i].op; funct3 = vecs[i].f3;
            funct7_5 = vecs[i].f75; Zero = vecs[i].zero; mem_ready = vecs[i].mr;
            #2;
            check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
        end

        latency(LW, 5, "lat_lw");
        latency(BQ, 3, "lat_beq");
        latency(RT, 4, "lat_r");
        latency(JL, 4, "lat_jal");
        latency(SW, 4, "lat_sw");

        // reset dropped in the middle of a MEMREAD stall
        @(negedge clk); op = LW; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #2 check("memread_entry", int'(state), 3);
        @(negedge clk);
        #2 check("memread_stall", int'(state), 3);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1 check("rst_async_state", int'(state), 0);
        check("rst_async_strobes", int'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
        @(posedge clk); #1;
        check("rst_hold_state", int'(state), 0);
        check("rst_hold_strobes", int'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
        @(negedge clk); rst_n = 1'b1;
        #2 check("post_rst_fetch", int'({state, IRWrite, PCWrite}), 3);
        @(posedge clk); #1;
        check("post_rst_decode", int'(state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
